// File: rtl/hot_row_pkg.sv
// Shared defaults and types for the hot-row alert collector and its address FIFO.
package hot_row_pkg;

    localparam int DEF_ADDRESS_SIZE   = 16;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_PTR_WIDTH      = 3;
    localparam int DEF_DROP_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        GUARD = 2'd2
    } collector_state_t;

    typedef logic [DEF_ADDRESS_SIZE-1:0] hot_addr_t;

endpackage

// File: rtl/hot_addr_fifo.sv
// First-word-fall-through queue of hot row addresses with a per-entry match vector.
// Callers must not push when full without popping, and must not pop when empty.
module hot_addr_fifo
    import hot_row_pkg::*;
#(
    parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int PTR_WIDTH    = DEF_PTR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [ADDRESS_SIZE-1:0] wr_data,
    input  logic                    pop,
    output logic [ADDRESS_SIZE-1:0] rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [PTR_WIDTH:0]      count,
    input  logic                    match_en,
    input  logic [ADDRESS_SIZE-1:0] match_addr,
    output logic [FIFO_DEPTH-1:0]   match_vec
);

    logic [PTR_WIDTH:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [ADDRESS_SIZE-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]    slot_ofs;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PTR_WIDTH{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PTR_WIDTH{1'b0}}, pop};
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[PTR_WIDTH-1:0]] = wr_data;
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                     (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];

    // A slot is occupied when its distance from the head is below the occupancy.
    always_comb begin
        slot_ofs  = '0;
        match_vec = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot_ofs     = PTR_WIDTH'(i) - rd_ptr_q[PTR_WIDTH-1:0];
            match_vec[i] = match_en && ({1'b0, slot_ofs} < count) &&
                           (mem_q[i] == match_addr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/hot_row_alert_collector.sv
// Captures tracker hot-row alerts, acknowledges the tracker and queues addresses.
// Define HOT_ROW_DEDUP_EN to suppress captures already present in the queue.
//
// state | meaning
// IDLE  | waiting for alert; ref_addr latched on the cycle alert is seen
// ACK   | ref_read_en high; captured address pushed, dropped or deduplicated
// GUARD | alert ignored while the tracker clears it and realigns its phase
module hot_row_alert_collector
    import hot_row_pkg::*;
#(
    parameter int ADDRESS_SIZE   = DEF_ADDRESS_SIZE,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int PTR_WIDTH      = DEF_PTR_WIDTH,
    parameter int DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alert,
    input  logic [ADDRESS_SIZE-1:0]   ref_addr,
    output logic                      ref_read_en,
    output logic                      hot_valid,
    output logic [ADDRESS_SIZE-1:0]   hot_addr,
    input  logic                      hot_ready,
    output logic [PTR_WIDTH:0]        fifo_count,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic                      overflow
);

`ifdef HOT_ROW_DEDUP_EN
    localparam logic DEDUP_EN = 1'b1;
`else
    localparam logic DEDUP_EN = 1'b0;
`endif

    collector_state_t          state_q, state_d;
    logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
    logic                      ref_read_en_q, ref_read_en_d;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic                      overflow_q, overflow_d;

    logic                  fifo_empty, fifo_full;
    logic                  push, pop, drop, dup, in_ack;
    logic [FIFO_DEPTH-1:0] match_vec;

    hot_addr_fifo #(
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .PTR_WIDTH    (PTR_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .wr_data    (addr_q),
        .pop        (pop),
        .rd_data    (hot_addr),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count),
        .match_en   (DEDUP_EN),
        .match_addr (addr_q),
        .match_vec  (match_vec)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (alert) begin
                    addr_d  = ref_addr;
                    state_d = ACK;
                end
            end
            ACK:     state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ref_read_en_d = (state_d == ACK);

        // A pop on the ACK edge frees the slot the capture needs, so no drop then.
        in_ack = (state_q == ACK);
        pop    = !fifo_empty && hot_ready;
        dup    = |match_vec;
        push   = in_ack && !dup && (!fifo_full || pop);
        drop   = in_ack && !dup && fifo_full && !pop;

        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != {DROP_CNT_WIDTH{1'b1}})) begin
            drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
        end
        overflow_d = overflow_q || drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            ref_read_en_q <= 1'b0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            ref_read_en_q <= ref_read_en_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign ref_read_en = ref_read_en_q;
    assign hot_valid   = !fifo_empty;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_hot_row_alert_collector.sv
// Directed scoreboard bench for hot_row_alert_collector; a second instance with a
// 2-bit drop counter shares the stimulus to exercise counter saturation.
module tb_hot_row_alert_collector;
    import hot_row_pkg::*;

    logic        clk;
    logic        reset;
    logic        alert;
    logic [15:0] ref_addr;
    logic        hot_ready;

    logic        ref_read_en, hot_valid;
    logic [15:0] hot_addr;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_count;
    logic        overflow;

    logic        s_ref_read_en, s_hot_valid;
    logic [15:0] s_hot_addr;
    logic [3:0]  s_fifo_count;
    logic [1:0]  s_drop_count;
    logic        s_overflow;

    int        n_checks = 0;
    int        n_fail   = 0;
    int        pulses   = 0;
    hot_addr_t exp_q[$];

    hot_row_alert_collector dut (
        .clk(clk), .reset(reset), .alert(alert), .ref_addr(ref_addr),
        .ref_read_en(ref_read_en), .hot_valid(hot_valid), .hot_addr(hot_addr),
        .hot_ready(hot_ready), .fifo_count(fifo_count), .drop_count(drop_count),
        .overflow(overflow)
    );

    hot_row_alert_collector #(.DROP_CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset(reset), .alert(alert), .ref_addr(ref_addr),
        .ref_read_en(s_ref_read_en), .hot_valid(s_hot_valid), .hot_addr(s_hot_addr),
        .hot_ready(hot_ready), .fifo_count(s_fifo_count), .drop_count(s_drop_count),
        .overflow(s_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head is compared with the oldest expected address.
    always @(negedge clk) begin
        if (ref_read_en) pulses++;
        if (!reset && hot_valid && hot_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'(hot_addr), 32'hFFFF_FFFF);
            end else begin
                check("head_addr", 32'(hot_addr), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_alert(input logic [15:0] a, input bit pop_in_ack, input bit rst_in_ack);
        bit seen = 1'b0;
        @(posedge clk); #1;
        alert    = 1'b1;
        ref_addr = a;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (ref_read_en) seen = 1'b1;
        end
        alert = 1'b0;
        if (!seen) begin
            check("ack_timeout", 32'd0, 32'd1);
            return;
        end
        if (rst_in_ack) begin
            #2 reset = 1'b1;
            #1;
            check("rst_ref_read_en", 32'(ref_read_en), 32'd0);
            check("rst_hot_valid",   32'(hot_valid),   32'd0);
            check("rst_fifo_count",  32'(fifo_count),  32'd0);
            check("rst_drop_count",  32'(drop_count),  32'd0);
            check("rst_overflow",    32'(overflow),    32'd0);
            return;
        end
        if (pop_in_ack) hot_ready = 1'b1;
        @(posedge clk); #1;
        if (pop_in_ack) hot_ready = 1'b0;
        check("ack_one_cycle", 32'(ref_read_en), 32'd0);
        @(posedge clk);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        hot_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!hot_valid) break;
        end
        hot_ready = 1'b0;
        check("drain_count", 32'(fifo_count), 32'd0);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        hot_addr_t a;
        reset     = 1'b1;
        alert     = 1'b0;
        ref_addr  = '0;
        hot_ready = 1'b0;
        #8;
        check("reset_ref_read_en", 32'(ref_read_en), 32'd0);
        check("reset_hot_valid",   32'(hot_valid),   32'd0);
        check("reset_hot_addr",    32'(hot_addr),    32'd0);
        check("reset_fifo_count",  32'(fifo_count),  32'd0);
        check("reset_drop_count",  32'(drop_count),  32'd0);
        check("reset_overflow",    32'(overflow),    32'd0);
        #4 reset = 1'b0;

        // Single alert
        p0 = pulses;
        exp_q.push_back(16'h1234);
        do_alert(16'h1234, 1'b0, 1'b0);
        check("single_valid", 32'(hot_valid),  32'd1);
        check("single_addr",  32'(hot_addr),   32'h1234);
        check("single_count", 32'(fifo_count), 32'd1);
        check("single_pulses", 32'(pulses - p0), 32'd1);
        drain();

        // Dedup
        p0 = pulses;
        exp_q.push_back(16'h00AA);
        exp_q.push_back(16'h00BB);
        do_alert(16'h00AA, 1'b0, 1'b0);
        do_alert(16'h00BB, 1'b0, 1'b0);
        do_alert(16'h00AA, 1'b0, 1'b0);
`ifdef HOT_ROW_DEDUP_EN
        check("dedup_count", 32'(fifo_count), 32'd2);
`else
        exp_q.push_back(16'h00AA);
        check("dedup_count", 32'(fifo_count), 32'd3);
`endif
        check("dedup_pulses", 32'(pulses - p0), 32'd3);
        check("dedup_drops",  32'(drop_count),  32'd0);
        drain();

        // Fill and overflow
        p0 = pulses;
        for (int i = 1; i <= 9; i++) begin
            a = hot_addr_t'(i);
            if (i <= 8) exp_q.push_back(a);
            do_alert(a, 1'b0, 1'b0);
        end
        check("ovf_pulses", 32'(pulses - p0), 32'd9);
        check("ovf_count",  32'(fifo_count),  32'd8);
        check("ovf_drops",  32'(drop_count),  32'd1);
        check("ovf_flag",   32'(overflow),    32'd1);
        check("ovf_head",   32'(hot_addr),    32'h0001);
        drain();

        // Full with simultaneous pop in ACK
        for (int i = 0; i < 8; i++) begin
            a = 16'h0011 + hot_addr_t'(i);
            exp_q.push_back(a);
            do_alert(a, 1'b0, 1'b0);
        end
        check("full_count", 32'(fifo_count), 32'd8);
        exp_q.push_back(16'h00FF);
        do_alert(16'h00FF, 1'b1, 1'b0);
        check("fullpop_count", 32'(fifo_count), 32'd8);
        check("fullpop_drops", 32'(drop_count), 32'd1);
        drain();

        // Drop saturation (FIFO_DEPTH + 5 alerts, 5 drops)
        for (int i = 0; i < 13; i++) begin
            a = 16'h0021 + hot_addr_t'(i);
            if (i < 8) exp_q.push_back(a);
            do_alert(a, 1'b0, 1'b0);
        end
        check("sat_count",      32'(fifo_count),   32'd8);
        check("sat_drops_w8",   32'(drop_count),   32'd6);
        check("sat_drops_w2",   32'(s_drop_count), 32'd3);
        check("sat_overflow_w2", 32'(s_overflow),  32'd1);
        drain();

        // Reset during ACK with three entries queued
        for (int i = 0; i < 3; i++) begin
            a = 16'h0031 + hot_addr_t'(i);
            exp_q.push_back(a);
            do_alert(a, 1'b0, 1'b0);
        end
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        do_alert(16'h0034, 1'b0, 1'b1);
        exp_q.delete();
        #10 reset = 1'b0;
        p0 = pulses;
        exp_q.push_back(16'h5555);
        do_alert(16'h5555, 1'b0, 1'b0);
        check("post_rst_pulses", 32'(pulses - p0), 32'd1);
        check("post_rst_count",  32'(fifo_count),  32'd1);
        check("post_rst_addr",   32'(hot_addr),    32'h5555);
        check("post_rst_drops",  32'(drop_count),  32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
